// File: rtl/mux_lut_loader_pkg.sv
// Shared width helpers for the mux_lut loader slice.
// Keeps index/count sizing identical between loader and matcher.
package mux_lut_loader_pkg;

  function automatic int idx_w(input int nr);
    return (nr > 1) ? $clog2(nr) : 1;
  endfunction

  function automatic int cnt_w(input int nr);
    return $clog2(nr + 1);
  endfunction

endpackage

// File: rtl/mux_lut_match.sv
// Combinational key compare over occupied table entries.
// Reports any hit plus the lowest-index hit.
module mux_lut_match
  import mux_lut_loader_pkg::*;
#(
  parameter int NR = 2,
  parameter int KW = 1,
  localparam int IW = idx_w(NR)
) (
  input  logic [NR*KW-1:0] keys,
  input  logic [NR-1:0]    occ,
  input  logic [KW-1:0]    key,
  output logic             match,
  output logic [IW-1:0]    match_idx
);

  // Scan downward so the lowest index wins.
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    for (int i = NR - 1; i >= 0; i--) begin
      if (occ[i] && keys[i*KW +: KW] == key) begin
        match     = 1'b1;
        match_idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/mux_lut_loader.sv
// Writable key/value table driving a lookup mux's packed lut bus.
// Appends new keys in order, updates existing keys in place.
module mux_lut_loader
  import mux_lut_loader_pkg::*;
#(
  parameter int          NR      = 2,
  parameter int          KW      = 1,
  parameter int          DW      = 1,
  parameter logic [KW-1:0] RST_KEY = '0,
  localparam int         EW      = KW + DW,
  localparam int         CW      = cnt_w(NR),
  localparam int         IW      = idx_w(NR)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [KW-1:0]      in_key,
  input  logic [DW-1:0]      in_val,
  output logic [NR*EW-1:0]   lut,
  output logic [CW-1:0]      count,
  output logic               full,
  output logic               wr_hit
);

  logic [NR-1:0][KW-1:0] keys_q, keys_d;
  logic [NR-1:0][DW-1:0] vals_q, vals_d;
  logic [NR-1:0]         occ_q, occ_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  hit_q, hit_d;
  logic                  match;
  logic [IW-1:0]         match_idx;
  logic                  accept;

  mux_lut_match #(
    .NR (NR),
    .KW (KW)
  ) u_match (
    .keys      (keys_q),
    .occ       (occ_q),
    .key       (in_key),
    .match     (match),
    .match_idx (match_idx)
  );

  assign full     = (cnt_q == CW'(NR));
  assign in_ready = !clr && (match || !full);
  assign accept   = in_valid && in_ready;

  always_comb begin
    keys_d = keys_q;
    vals_d = vals_q;
    occ_d  = occ_q;
    cnt_d  = cnt_q;
    hit_d  = 1'b0;
    if (clr) begin
      for (int i = 0; i < NR; i++) begin
        keys_d[i] = RST_KEY;
        vals_d[i] = '0;
      end
      occ_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      if (match) begin
        hit_d = 1'b1;
        for (int i = 0; i < NR; i++)
          if (IW'(i) == match_idx)
            vals_d[i] = in_val;
      end else begin
        // No hole can exist, so count is the next free slot.
        for (int i = 0; i < NR; i++) begin
          if (CW'(i) == cnt_q) begin
            keys_d[i] = in_key;
            vals_d[i] = in_val;
            occ_d[i]  = 1'b1;
          end
        end
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) begin
        keys_q[i] <= RST_KEY;
        vals_q[i] <= '0;
      end
      occ_q <= '0;
      cnt_q <= '0;
      hit_q <= 1'b0;
    end else begin
      keys_q <= keys_d;
      vals_q <= vals_d;
      occ_q  <= occ_d;
      cnt_q  <= cnt_d;
      hit_q  <= hit_d;
    end
  end

  for (genvar n = 0; n < NR; n++) begin : g_lut
    assign lut[EW*n +: EW] = {keys_q[n], vals_q[n]};
  end

  assign count  = cnt_q;
  assign wr_hit = hit_q;

endmodule

// File: tb/tb_mux_lut_loader.sv
// Directed vector bench for mux_lut_loader (NR=4, KW=4, DW=8).
// Includes a behavioural model of the downstream lookup mux.
module tb_mux_lut_loader;

  localparam int NR = 4;
  localparam int KW = 4;
  localparam int DW = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_key;
  logic [7:0]  in_val;
  logic [47:0] lut;
  logic [2:0]  count;
  logic        full;
  logic        wr_hit;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  mux_lut_loader #(
    .NR      (NR),
    .KW      (KW),
    .DW      (DW),
    .RST_KEY (4'hF)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_key   (in_key),
    .in_val   (in_val),
    .lut      (lut),
    .count    (count),
    .full     (full),
    .wr_hit   (wr_hit)
  );

  typedef struct {
    logic        clr;
    logic        vld;
    logic [3:0]  key;
    logic [7:0]  val;
    logic        rdy;
    logic [2:0]  cnt;
    logic        full;
    logic        hit;
    logic [47:0] lut;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic c, input logic v, input logic [3:0] k,
    input logic [7:0] d, input logic r, input logic [2:0] n,
    input logic f, input logic h, input logic [47:0] l);
    vec_t t;
    t.clr = c; t.vld = v; t.key = k; t.val = d; t.rdy = r;
    t.cnt = n; t.full = f; t.hit = h; t.lut = l;
    return t;
  endfunction

  // Downstream mux: first entry whose key equals sel, else def.
  function automatic logic [7:0] mux_model(
    input logic [47:0] l, input logic [3:0] sel, input logic [7:0] def);
    logic [7:0] r;
    r = def;
    for (int i = NR - 1; i >= 0; i--)
      if (l[12*i+8 +: 4] == sel) r = l[12*i +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  initial begin
    rst_n    = 1'b1;
    clr      = 1'b0;
    in_valid = 1'b0;
    in_key   = 4'h0;
    in_val   = 8'h00;

    #3 rst_n = 1'b0;
    #1;
    check("rst_lut", 64'(lut), 64'h0000_F00F_00F0_0F00);
    check("rst_count", 64'(count), 64'd0);
    check("rst_full", 64'(full), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_hit", 64'(wr_hit), 64'd0);
    #12 rst_n = 1'b1;

    vecs.push_back(mk(0,1,4'h1,8'hAA,1,3'd1,0,0,48'hF00_F00_F00_1AA));
    vecs.push_back(mk(0,1,4'h2,8'hBB,1,3'd2,0,0,48'hF00_F00_2BB_1AA));
    vecs.push_back(mk(0,1,4'h1,8'h55,1,3'd2,0,1,48'hF00_F00_2BB_155));
    vecs.push_back(mk(0,0,4'h0,8'h00,1,3'd2,0,0,48'hF00_F00_2BB_155));
    vecs.push_back(mk(0,1,4'h3,8'h33,1,3'd3,0,0,48'hF00_333_2BB_155));
    vecs.push_back(mk(0,1,4'h4,8'h44,1,3'd4,1,0,48'h444_333_2BB_155));
    vecs.push_back(mk(0,1,4'h5,8'h66,0,3'd4,1,0,48'h444_333_2BB_155));
    vecs.push_back(mk(0,1,4'h5,8'h66,0,3'd4,1,0,48'h444_333_2BB_155));
    vecs.push_back(mk(0,1,4'h5,8'h66,0,3'd4,1,0,48'h444_333_2BB_155));
    vecs.push_back(mk(0,1,4'h3,8'h77,1,3'd4,1,1,48'h444_377_2BB_155));
    vecs.push_back(mk(1,1,4'h6,8'h99,0,3'd0,0,0,48'hF00_F00_F00_F00));
    vecs.push_back(mk(0,1,4'h6,8'h99,1,3'd1,0,0,48'hF00_F00_F00_699));
    vecs.push_back(mk(0,1,4'h2,8'h42,1,3'd2,0,0,48'hF00_F00_242_699));
    vecs.push_back(mk(0,0,4'h2,8'h00,1,3'd2,0,0,48'hF00_F00_242_699));

    @(posedge clk);
    foreach (vecs[i]) begin
      @(negedge clk);
      clr      = vecs[i].clr;
      in_valid = vecs[i].vld;
      in_key   = vecs[i].key;
      in_val   = vecs[i].val;
      #1;
      check($sformatf("v%0d_ready", i), 64'(in_ready), 64'(vecs[i].rdy));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_count", i), 64'(count), 64'(vecs[i].cnt));
      check($sformatf("v%0d_full", i), 64'(full), 64'(vecs[i].full));
      check($sformatf("v%0d_hit", i), 64'(wr_hit), 64'(vecs[i].hit));
      check($sformatf("v%0d_lut", i), 64'(lut), 64'(vecs[i].lut));
    end

    @(negedge clk);
    clr      = 1'b0;
    in_valid = 1'b0;

    check("e2e_sel2", 64'(mux_model(lut, 4'h2, 8'hEE)), 64'h42);
    check("e2e_sel7", 64'(mux_model(lut, 4'h7, 8'hEE)), 64'hEE);
    check("e2e_selF", 64'(mux_model(lut, 4'hF, 8'hEE)), 64'h00);

    // Async reset mid-cycle on a populated table.
    #2 rst_n = 1'b0;
    #1;
    check("rst2_lut", 64'(lut), 64'h0000_F00F_00F0_0F00);
    check("rst2_count", 64'(count), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    in_key   = 4'hF;
    in_val   = 8'h12;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("rstkey_app", 64'(lut), 64'h0000_F00F_00F0_0F12);
    check("rstkey_cnt", 64'(count), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
